fft_addr_gen: RTL

Butterfly address sequencer for the 8-point radix-2 DIT FFT. It issues, per stage, four in-place butterfly address pairs (a, b) with twiddle index and valid. These feed the datapath and the address pipe that tracks butterfly latency. It counts returned write-back valids from the address pipe and holds the next stage until the previous stage has fully drained, which avoids in-place read-after-write hazards.

---
 rtl/fft_addr_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: butterfly address sequencer for an 8-point radix-2 DIT FFT.
//
// Each pass runs three stages. In every stage the block issues four in-place
// butterflies (a, b, twiddle), one per cycle. It then waits until all four
// write-backs have come back from the address pipe before the next stage
// starts, so a stage never reads a location that is still being written.
// A drain watchdog aborts the pass if write-backs stop arriving.
//
// Ports
//   clk, rst   clock (rising edge), synchronous active-high reset
//   start      one-cycle request to begin a pass (accepted only in IDLE)
//   wb_v       write-back valid from the address pipe, one per butterfly
//   v_out      butterfly issue valid
//   a_out      top-leg address
//   b_out      bottom-leg address (a_out + 2^stage)
//   tw_out     twiddle index k (W8^k)
//   stage_out  current stage 0..2
//   busy       high from first issue until done or error
//   done       one-cycle pulse after stage 2 has fully written back
//   err        sticky drain-timeout flag, cleared by the next start or rst
module fft_addr_gen #(
  parameter int LAT  = 7,
  parameter int N_BF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       wb_v,
  output logic       v_out,
  output logic [2:0] a_out,
  output logic [2:0] b_out,
  output logic [1:0] tw_out,
  output logic [1:0] stage_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int          WD_LIMIT = LAT + 4;
  localparam int          WD_W     = $clog2(WD_LIMIT + 1);
  localparam logic [1:0]  K_LAST   = 2'(N_BF - 1);
  localparam logic [2:0]  CNT_FULL = 3'(N_BF);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              v_d, busy_d, done_d, err_d;
  logic [2:0]        a_d, b_d;
  logic [1:0]        tw_d, stage_d;
  logic [2:0]        cnt_inc;

  // Butterfly k of stage s: half = 2^s, j = k mod half,
  // a = (k / half) * 2 * half + j, b = a + half, tw = j * 2^(2-s).
  function automatic logic [7:0] bf_addr(input logic [1:0] s, input logic [1:0] k);
    logic [2:0] half, j, a, b;
    logic [1:0] tw;
    half = 3'd1 << s;
    j    = {1'b0, k} & (half - 3'd1);
    a    = 3'(({1'b0, k} >> s) << (s + 2'd1)) + j;
    b    = a + half;
    tw   = 2'(j << (2'd2 - s));
    return {a, b, tw};
  endfunction

  assign cnt_inc = cnt_q + {2'b00, wb_v};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    v_d     = 1'b0;
    a_d     = a_out;
    b_d     = b_out;
    tw_d    = tw_out;
    stage_d = stage_out;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = err;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d           = ISSUE;
          stage_d           = 2'd0;
          k_d               = 2'd0;
          cnt_d             = 3'd0;
          wd_d              = '0;
          v_d               = 1'b1;
          {a_d, b_d, tw_d}  = bf_addr(2'd0, 2'd0);
          busy_d            = 1'b1;
          err_d             = 1'b0;
        end
      end
      ISSUE: begin
        // write-backs can already return while issuing when LAT is short
        cnt_d = cnt_inc;
        wd_d  = '0;
        if (k_q == K_LAST) begin
          state_d = DRAIN;
        end else begin
          k_d              = k_q + 2'd1;
          v_d              = 1'b1;
          {a_d, b_d, tw_d} = bf_addr(stage_out, k_q + 2'd1);
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= CNT_FULL) begin
          cnt_d = 3'd0;
          wd_d  = '0;
          if (stage_out != 2'd2) begin
            state_d          = ISSUE;
            stage_d          = stage_out + 2'd1;
            k_d              = 2'd0;
            v_d              = 1'b1;
            {a_d, b_d, tw_d} = bf_addr(stage_out + 2'd1, 2'd0);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else if (wb_v) begin
          wd_d = '0;
        end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
          // this is the WD_LIMIT-th consecutive silent cycle
          state_d = IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      v_out     <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      tw_out    <= '0;
      stage_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      v_out     <= v_d;
      a_out     <= a_d;
      b_out     <= b_d;
      tw_out    <= tw_d;
      stage_out <= stage_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule
